i2c_line_conditioner: RTL and testbench

Front-end for the I2C target path. Synchronises raw SCL/SDA pad inputs into the clk domain and generates a divided sample strobe. Removes glitches with a consecutive-sample filter, then emits clean levels, SCL edge pulses and START / repeated-START / STOP pulses plus a bus-busy flag. Sits directly upstream of the I2C peripheral controller and drives its condition inputs.

---
 rtl/i2c_line_conditioner.sv | 181 ++++++++++++++++++
 tb/tb_i2c_line_conditioner.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_line_conditioner.sv
// i2c_line_conditioner: pad synchroniser, sample-strobe divider, per-line
// glitch filter and START / repeated-START / STOP / bus-busy detection for
// the I2C target path.
// Optional feature macro: I2C_TIMEOUT_EN (SCL stuck-low timeout while busy).
module i2c_line_conditioner #(
  parameter int unsigned SAMPLE_DIV    = 32,
  parameter int unsigned FILTER_LEN    = 3,
  parameter int unsigned TIMEOUT_TICKS = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sample_tick,
  output logic scl_filt,
  output logic sda_filt,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_pulse,
  output logic rstart_pulse,
  output logic stop_pulse,
  output logic bus_busy,
  output logic timeout_pulse
);

  localparam int unsigned DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned FILT_W = 4;

  // Parameter range guards, evaluated at elaboration
  if (SAMPLE_DIV < 1 || SAMPLE_DIV > 255) begin : g_bad_div
    $error("SAMPLE_DIV must be in 1..255");
  end
  if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filt
    $error("FILTER_LEN must be in 1..15");
  end
  if (TIMEOUT_TICKS < 1) begin : g_bad_timeout
    $error("TIMEOUT_TICKS must be at least 1");
  end

  logic              scl_meta, scl_sync, sda_meta, sda_sync;
  logic [DIV_W-1:0]  div_cnt, div_nxt;
  logic [FILT_W-1:0] scl_cnt, scl_cnt_nxt, sda_cnt, sda_cnt_nxt;
  logic              scl_new, sda_new;
  logic              scl_high_both, start_det, stop_det;
  logic              timeout_det;

  // Two-flop synchroniser per pad line; idle-high reset matches a released bus
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
    end else begin
      scl_meta <= scl_in;
      scl_sync <= scl_meta;
      sda_meta <= sda_in;
      sda_sync <= sda_meta;
    end
  end

  // Divider next count; strobe is registered so it is high while count is DIV-1
  always_comb begin
    div_nxt = div_cnt + DIV_W'(1);
    if (div_cnt == DIV_W'(SAMPLE_DIV - 1)) begin
      div_nxt = '0;
    end
  end

  // Divider counter and sample strobe register
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      sample_tick <= 1'b0;
    end else begin
      div_cnt     <= div_nxt;
      sample_tick <= (div_nxt == DIV_W'(SAMPLE_DIV - 1));
    end
  end

  // Consecutive-disagreement filter for both lines, stepped on sample_tick
  always_comb begin
    scl_new     = scl_filt;
    scl_cnt_nxt = scl_cnt;
    sda_new     = sda_filt;
    sda_cnt_nxt = sda_cnt;
    if (sample_tick) begin
      if (scl_sync == scl_filt) begin
        scl_cnt_nxt = '0;
      end else if (scl_cnt == FILT_W'(FILTER_LEN - 1)) begin
        scl_new     = ~scl_filt;
        scl_cnt_nxt = '0;
      end else begin
        scl_cnt_nxt = scl_cnt + FILT_W'(1);
      end
      if (sda_sync == sda_filt) begin
        sda_cnt_nxt = '0;
      end else if (sda_cnt == FILT_W'(FILTER_LEN - 1)) begin
        sda_new     = ~sda_filt;
        sda_cnt_nxt = '0;
      end else begin
        sda_cnt_nxt = sda_cnt + FILT_W'(1);
      end
    end
  end

  // Bus conditions need SCL high across the update, so a same-tick SCL edge masks them
  always_comb begin
    scl_high_both = scl_filt & scl_new;
    start_det     = scl_high_both & sda_filt & ~sda_new;
    stop_det      = scl_high_both & ~sda_filt & sda_new;
  end

`ifdef I2C_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

  logic [TO_W-1:0] stuck_cnt, stuck_nxt;

  // Count strobes spent busy with SCL low; fire on the TIMEOUT_TICKS-th one
  always_comb begin
    stuck_nxt   = stuck_cnt;
    timeout_det = 1'b0;
    if (!(bus_busy && !scl_filt)) begin
      stuck_nxt = '0;
    end else if (sample_tick) begin
      if (stuck_cnt == TO_W'(TIMEOUT_TICKS - 1)) begin
        timeout_det = 1'b1;
        stuck_nxt   = '0;
      end else begin
        stuck_nxt = stuck_cnt + TO_W'(1);
      end
    end
  end

  // Stuck counter and timeout pulse register
  always_ff @(posedge clk) begin
    if (reset) begin
      stuck_cnt     <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      stuck_cnt     <= stuck_nxt;
      timeout_pulse <= timeout_det;
    end
  end
`else
  assign timeout_det   = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

  // Filtered levels, edge / condition pulses and bus-busy tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_cnt      <= '0;
      sda_cnt      <= '0;
      scl_filt     <= 1'b1;
      sda_filt     <= 1'b1;
      scl_rise     <= 1'b0;
      scl_fall     <= 1'b0;
      start_pulse  <= 1'b0;
      rstart_pulse <= 1'b0;
      stop_pulse   <= 1'b0;
      bus_busy     <= 1'b0;
    end else begin
      scl_cnt      <= scl_cnt_nxt;
      sda_cnt      <= sda_cnt_nxt;
      scl_filt     <= scl_new;
      sda_filt     <= sda_new;
      scl_rise     <= ~scl_filt & scl_new;
      scl_fall     <= scl_filt & ~scl_new;
      start_pulse  <= start_det & ~bus_busy;
      rstart_pulse <= start_det & bus_busy;
      stop_pulse   <= stop_det;
      if (start_det) begin
        bus_busy <= 1'b1;
      end else if (stop_det || timeout_det) begin
        bus_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// Self-checking bench for i2c_line_conditioner: directed bus scenarios plus
// randomized line activity, compared every cycle against a behavioural model.
module tb_i2c_line_conditioner;

  localparam int unsigned SAMPLE_DIV    = 4;
  localparam int unsigned FILTER_LEN    = 3;
  localparam int unsigned TIMEOUT_TICKS = 8;

  logic clk = 1'b0;
  logic reset, scl_in, sda_in;
  logic sample_tick, scl_filt, sda_filt, scl_rise, scl_fall;
  logic start_pulse, rstart_pulse, stop_pulse, bus_busy, timeout_pulse;

  i2c_line_conditioner #(
    .SAMPLE_DIV   (SAMPLE_DIV),
    .FILTER_LEN   (FILTER_LEN),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .scl_in       (scl_in),
    .sda_in       (sda_in),
    .sample_tick  (sample_tick),
    .scl_filt     (scl_filt),
    .sda_filt     (sda_filt),
    .scl_rise     (scl_rise),
    .scl_fall     (scl_fall),
    .start_pulse  (start_pulse),
    .rstart_pulse (rstart_pulse),
    .stop_pulse   (stop_pulse),
    .bus_busy     (bus_busy),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Scenario observations taken from the DUT, judged against spec-derived constants
  int c_start, c_rstart, c_stop, c_rise, c_fall, c_to;
  int start_cyc, sda_low_cyc, sda_low_seen, to_scl;

  // Behavioural model state
  logic h_scl0, h_scl1, h_sda0, h_sda1;
  int   m_edges;
  logic m_tick, m_scl, m_sda, m_rise, m_fall;
  logic m_start, m_rstart, m_stop, m_busy, m_to;
  int   run_scl, run_sda;
`ifdef I2C_TIMEOUT_EN
  int   m_low_ticks;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [9:0] dut_outs();
    return {sample_tick, scl_filt, sda_filt, scl_rise, scl_fall,
            start_pulse, rstart_pulse, stop_pulse, bus_busy, timeout_pulse};
  endfunction

  function automatic logic [9:0] model_outs();
    return {m_tick, m_scl, m_sda, m_rise, m_fall,
            m_start, m_rstart, m_stop, m_busy, m_to};
  endfunction

  // A line accepts a new level once FILTER_LEN samples in a row disagree with it
  task automatic filt_step(input logic s, inout logic lvl, inout int run);
    if (s != lvl) run++;
    else          run = 0;
    if (run == int'(FILTER_LEN)) begin
      lvl = ~lvl;
      run = 0;
    end
  endtask

  // Advance the model by one clock edge given the inputs present at that edge
  task automatic model_edge(input logic r, input logic s_in, input logic d_in);
    logic os, od, ns, nd, st, sp;
    if (r) begin
      {h_scl0, h_scl1, h_sda0, h_sda1} = 4'b1111;
      m_edges = 0;
      m_tick  = 1'b0;
      m_scl   = 1'b1;
      m_sda   = 1'b1;
      {m_rise, m_fall, m_start, m_rstart, m_stop, m_busy, m_to} = '0;
      run_scl = 0;
      run_sda = 0;
`ifdef I2C_TIMEOUT_EN
      m_low_ticks = 0;
`endif
    end else begin
      os = m_scl;
      od = m_sda;
      ns = os;
      nd = od;
      // Synchronised level seen now is the pad value from two edges earlier
      if (m_tick) begin
        filt_step(h_scl1, ns, run_scl);
        filt_step(h_sda1, nd, run_sda);
      end
      m_rise   = !os && ns;
      m_fall   = os && !ns;
      st       = os && ns && od && !nd;
      sp       = os && ns && !od && nd;
      m_start  = st && !m_busy;
      m_rstart = st && m_busy;
      m_stop   = sp;
      m_to     = 1'b0;
`ifdef I2C_TIMEOUT_EN
      if (m_busy && !os) begin
        if (m_tick) begin
          m_low_ticks++;
          if (m_low_ticks == int'(TIMEOUT_TICKS)) begin
            m_to        = 1'b1;
            m_low_ticks = 0;
          end
        end
      end else begin
        m_low_ticks = 0;
      end
`endif
      if (st)             m_busy = 1'b1;
      else if (sp || m_to) m_busy = 1'b0;
      m_scl  = ns;
      m_sda  = nd;
      h_scl1 = h_scl0;
      h_scl0 = s_in;
      h_sda1 = h_sda0;
      h_sda0 = d_in;
      m_edges++;
      m_tick = (m_edges % int'(SAMPLE_DIV)) == int'(SAMPLE_DIV) - 1;
    end
  endtask

  task automatic clr_counts();
    c_start = 0; c_rstart = 0; c_stop = 0; c_rise = 0; c_fall = 0; c_to = 0;
    start_cyc = -1; sda_low_cyc = -1; sda_low_seen = 0; to_scl = -1;
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later
  task automatic step();
    @(posedge clk);
    model_edge(reset, scl_in, sda_in);
    #1;
    cyc++;
    check_eq("outs", 32'(dut_outs()), 32'(model_outs()));
    c_start  += int'(start_pulse);
    c_rstart += int'(rstart_pulse);
    c_stop   += int'(stop_pulse);
    c_rise   += int'(scl_rise);
    c_fall   += int'(scl_fall);
    c_to     += int'(timeout_pulse);
    if (start_pulse && start_cyc < 0) start_cyc = cyc;
    if (!sda_filt && sda_low_cyc < 0) sda_low_cyc = cyc;
    if (!sda_filt) sda_low_seen = 1;
    if (timeout_pulse) to_scl = int'(scl_filt);
  endtask

  task automatic hold(input logic s, input logic d, input int n);
    scl_in = s;
    sda_in = d;
    repeat (n) step();
  endtask

  initial begin
    logic [7:0] tick_pat;
    int         c0;

    reset  = 1'b1;
    scl_in = 1'b1;
    sda_in = 1'b1;
    clr_counts();
    repeat (5) step();
    check_eq("rst_outs", 32'(dut_outs()), 32'(10'b0110000000));

    // Strobe phase after release: high after edges 3 and 7
    reset       = 1'b0;
    tick_pat    = '0;
    tick_pat[0] = sample_tick;
    for (int i = 1; i < 8; i++) begin
      step();
      tick_pat[i] = sample_tick;
    end
    check_eq("tick_phase", 32'(tick_pat), 32'(8'h88));

    // Two-sample SDA glitch must be rejected
    clr_counts();
    hold(1'b1, 1'b0, 8);
    hold(1'b1, 1'b1, 24);
    check_eq("glitch_sda", 32'(sda_low_seen), 32'd0);
    check_eq("glitch_start", 32'(c_start), 32'd0);

    // START on idle bus
    clr_counts();
    c0 = cyc;
    hold(1'b1, 1'b0, 30);
    check_eq("start_cnt", 32'(c_start), 32'd1);
    check_eq("start_rstart", 32'(c_rstart), 32'd0);
    check_eq("start_busy", 32'(bus_busy), 32'd1);
    check_eq("start_same_cyc", 32'(start_cyc), 32'(sda_low_cyc));
    check_eq("start_latency", 32'((sda_low_cyc - c0 >= 11) && (sda_low_cyc - c0 <= 14)), 32'd1);

    // Repeated START
    clr_counts();
    hold(1'b0, 1'b0, 20);
    hold(1'b0, 1'b1, 20);
    hold(1'b1, 1'b1, 20);
    hold(1'b1, 1'b0, 20);
    check_eq("rs_cnt", 32'(c_rstart), 32'd1);
    check_eq("rs_start", 32'(c_start), 32'd0);
    check_eq("rs_stop", 32'(c_stop), 32'd0);
    check_eq("rs_busy", 32'(bus_busy), 32'd1);

    // STOP
    clr_counts();
    hold(1'b0, 1'b0, 20);
    hold(1'b1, 1'b0, 20);
    hold(1'b1, 1'b1, 20);
    check_eq("stop_cnt", 32'(c_stop), 32'd1);
    check_eq("stop_busy", 32'(bus_busy), 32'd0);
    check_eq("stop_starts", 32'(c_start + c_rstart), 32'd0);

    // SCL and SDA fall together: edge pulse only
    clr_counts();
    hold(1'b0, 1'b0, 20);
    check_eq("sim_fall", 32'(c_fall), 32'd1);
    check_eq("sim_rise", 32'(c_rise), 32'd0);
    check_eq("sim_cond", 32'(c_start + c_rstart + c_stop), 32'd0);
    check_eq("sim_levels", 32'({scl_filt, sda_filt}), 32'd0);

    // Back to idle (STOP on an idle bus still pulses), START, then hold SCL low
    hold(1'b1, 1'b0, 20);
    clr_counts();
    hold(1'b1, 1'b1, 20);
    check_eq("idle_stop_cnt", 32'(c_stop), 32'd1);
    clr_counts();
    hold(1'b1, 1'b0, 20);
    check_eq("to_start", 32'(c_start), 32'd1);
    clr_counts();
    hold(1'b0, 1'b0, 60);
`ifdef I2C_TIMEOUT_EN
    check_eq("to_cnt", 32'(c_to), 32'd1);
    check_eq("to_scl_low", 32'(to_scl), 32'd0);
    check_eq("to_busy", 32'(bus_busy), 32'd0);
`else
    check_eq("to_cnt", 32'(c_to), 32'd0);
    check_eq("to_busy", 32'(bus_busy), 32'd1);
`endif
    hold(1'b1, 1'b0, 20);
    clr_counts();
    hold(1'b1, 1'b1, 20);
    check_eq("late_stop_cnt", 32'(c_stop), 32'd1);
    check_eq("late_stop_busy", 32'(bus_busy), 32'd0);

    // Reset in the middle of a transfer
    hold(1'b1, 1'b0, 20);
    check_eq("mid_busy_pre", 32'(bus_busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("mid_rst_outs", 32'(dut_outs()), 32'(10'b0110000000));

    // Randomized line activity with occasional resets
    for (int seg = 0; seg < 250; seg++) begin
      if ($urandom_range(0, 29) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
      hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 24)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
